vector_writeback_sequencer: RTL and testbench
=============================================

Name: vector_writeback_sequencer

Overview:
- Writer-side front end of the vector register file.
- Takes one writeback command per vector instruction (destination base, VL, SEW, widening flag), then consumes padded 4-lane result beats from the PEs.
- Drives the register-file write port beat by beat: destination address, element count and de-padding mode.
- Sits between the PE array output and the register-file write port; pulses done when the instruction's last element is written.

Parameters:
- VLEN, 32, bits per vector register.
- LANES, 4, elements per PE result beat.
- VL_W, 5, width of the VL field (max VL 16 = LMUL4 x 4 x 8b).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous reset, active-high
- cmd_valid  in  1  writeback command valid
- cmd_ready  out  1  high only in IDLE
- cmd_vd_addr  in  5  destination base register
- cmd_vl  in  VL_W  elements to write
- cmd_vsew  in  2  0=8b, 1=16b, 2=32b
- cmd_widening  in  1  result width is 2*SEW
- res_valid  in  1  PE result beat valid
- res_ready  out  1  high in ACTIVE
- res_data  in  128  4 lanes x 32b, element right-aligned per lane
- wb_write  out  1  register-file write strobe
- wb_vd_addr  out  5  beat destination register
- wb_elements_to_write  out  2  0=all 4, 1..3=partial
- wb_vsew  out  2  SEW forwarded to the register file
- wb_widening  out  1  widening flag forwarded to the register file
- wb_vd_data  out  128  beat data
- done  out  1  one-cycle pulse at instruction completion
- err  out  1  one-cycle pulse alongside done for an illegal command
- stat_beats  out  16  beats written (optional feature)
- stat_stalls  out  16  ACTIVE cycles with no res_valid (optional feature)

Behaviour:
- Reset: state IDLE; all outputs 0 except cmd_ready=1; all counters 0.
- FSM states IDLE, ACTIVE, FINISH.
- IDLE: cmd_valid latches every cmd_* field; cmd_ready drops the next cycle.
  - Go to FINISH with err=1 if cmd_widening and cmd_vsew>=1.
  - Go to FINISH with err=1 if cmd_vsew=3.
  - Go to FINISH with err=0, no writes, if cmd_vl=0.
  - Otherwise go to ACTIVE.
- Effective SEW: eff = vsew + widening (8b widening gives eff 16b).
- Address step per beat: +1 for eff 8b, +2 for 16b, +4 for 32b. Address is 5-bit and wraps modulo 32; wrap is not flagged.
- ACTIVE: res_ready=1. Each res_valid&res_ready handshake registers one write. Outputs valid the cycle after acceptance (latency 1):
  - wb_write=1
  - wb_vd_addr = base + beat_idx*step
  - wb_vd_data = res_data
  - wb_vsew = latched vsew; wb_widening = latched flag
  - remaining = vl - done_cnt; wb_elements_to_write = 0 if remaining>=4, else remaining[1:0]
  - done_cnt += min(4, remaining)
- Last beat: when done_cnt reaches vl, res_ready drops the same cycle as the write is registered; go to FINISH. Extra beats are never accepted.
- FINISH: done=1 for one cycle (err as set above); wb_write=0; then IDLE.
- wb_write is 0 in every cycle without an accepted beat, even in ACTIVE. There is no downstream backpressure: the register file always accepts.
- cmd_valid outside IDLE is ignored; the command is held by the sender until cmd_ready.
- reset asserted mid-instruction: immediate return to IDLE, and any write being presented is dropped.
- vd_addr=0 is not filtered here; the register file itself inhibits writes to v0.

Optional Feature:
- AVA_WB_STATS_EN defined:
  - stat_beats increments per write.
  - stat_stalls increments per ACTIVE cycle with res_valid=0.
  - Both saturate at 16'hFFFF and clear only on reset.
- Undefined: both ports tied to 0; no counter flops.

Decomposition:
- Shared package ava_vec_pkg:
  - sew_e enum (SEW8, SEW16, SEW32)
  - wb_state_e enum
  - LANES and VLEN constants
  - wb_cmd_t struct (vd_addr, vl, vsew, widening)
- One natural sub-module: wb_beat_calc, combinational. Takes eff SEW, base, beat_idx, remaining; produces address and elements_to_write.

Test Plan:
- 8b, vd=4, vl=10 → 3 writes: addr 4,5,6; ete 0,0,2; then done pulse.
- 16b, vd=8, vl=8 → 2 writes: addr 8,10; ete 0,0; res_ready low after 2nd beat.
- 8b widening, vd=2, vl=3 → 1 write: addr 2, ete 3, wb_widening=1.
- 32b, vd=16, vl=4, res_valid gapped 2 idle cycles → single write addr 16 one cycle after handshake; with AVA_WB_STATS_EN, stat_stalls=2.
- Illegal 32b widening → no wb_write, done=err=1 two cycles after cmd; vl=0 → done=1, err=0, no write.
- Reset asserted after 1st of 3 beats → outputs 0, cmd_ready=1 next cycle, new command accepted cleanly.

Source files
------------

// File: rtl/ava_vec_pkg.sv
// Shared types and constants for the vector writeback path.
package ava_vec_pkg;

    localparam int VLEN  = 32;
    localparam int LANES = 4;
    localparam int VL_W  = 5;

    typedef enum logic [1:0] {
        SEW8  = 2'd0,
        SEW16 = 2'd1,
        SEW32 = 2'd2
    } sew_e;

    typedef enum logic [1:0] {
        WB_IDLE   = 2'd0,
        WB_ACTIVE = 2'd1,
        WB_FINISH = 2'd2
    } wb_state_e;

    typedef struct packed {
        logic [4:0]      vd_addr;
        logic [VL_W-1:0] vl;
        logic [1:0]      vsew;
        logic            widening;
    } wb_cmd_t;

    // Widening doubles the element width, so the result SEW is one step up.
    function automatic logic [1:0] eff_sew(input logic [1:0] vsew, input logic widening);
        return vsew + {1'b0, widening};
    endfunction

endpackage

// File: rtl/wb_beat_calc.sv
// Per-beat destination address and partial-beat element count.
module wb_beat_calc
    import ava_vec_pkg::*;
(
    input  sew_e            eff,
    input  logic [4:0]      base,
    input  logic [3:0]      beat_idx,
    input  logic [VL_W-1:0] remaining,
    output logic [4:0]      addr,
    output logic [1:0]      elements_to_write
);

    logic [4:0] offset_s;

    // One beat spans 1, 2 or 4 registers; the address wraps modulo 32.
    always_comb begin
        offset_s = 5'd0;
        case (eff)
            SEW8:    offset_s = {1'b0, beat_idx};
            SEW16:   offset_s = {beat_idx, 1'b0};
            SEW32:   offset_s = {beat_idx[2:0], 2'b00};
            default: offset_s = 5'd0;
        endcase
        addr = base + offset_s;
        if (remaining >= 5'd4) begin
            elements_to_write = 2'd0;
        end else begin
            elements_to_write = remaining[1:0];
        end
    end

endmodule

// File: rtl/vector_writeback_sequencer.sv
// Vector register-file writeback sequencer: one command, then padded 4-lane beats.
// Optional statistics counters when AVA_WB_STATS_EN is defined.
module vector_writeback_sequencer
    import ava_vec_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [4:0]              cmd_vd_addr,
    input  logic [VL_W-1:0]         cmd_vl,
    input  logic [1:0]              cmd_vsew,
    input  logic                    cmd_widening,
    input  logic                    res_valid,
    output logic                    res_ready,
    input  logic [LANES*VLEN-1:0]   res_data,
    output logic                    wb_write,
    output logic [4:0]              wb_vd_addr,
    output logic [1:0]              wb_elements_to_write,
    output logic [1:0]              wb_vsew,
    output logic                    wb_widening,
    output logic [LANES*VLEN-1:0]   wb_vd_data,
    output logic                    done,
    output logic                    err,
    output logic [15:0]             stat_beats,
    output logic [15:0]             stat_stalls
);

    wb_state_e       state_r;
    wb_cmd_t         cmd_r;
    logic [VL_W-1:0] done_cnt_r;
    logic [3:0]      beat_idx_r;
    logic            err_pend_r;

    logic [VL_W-1:0] remaining_s;
    logic [VL_W-1:0] take_s;
    logic [4:0]      addr_s;
    logic [1:0]      ete_s;
    sew_e            eff_s;
    logic            accept_s;
    logic            last_s;

    // Beat bookkeeping derived from the latched command.
    always_comb begin
        remaining_s = cmd_r.vl - done_cnt_r;
        eff_s       = sew_e'(eff_sew(cmd_r.vsew, cmd_r.widening));
        accept_s    = (state_r == WB_ACTIVE) && res_valid && res_ready;
        last_s      = (remaining_s <= 5'd4);
        if (ete_s == 2'd0) begin
            take_s = 5'd4;
        end else begin
            take_s = {3'b000, ete_s};
        end
    end

    wb_beat_calc u_beat_calc (
        .eff               (eff_s),
        .base              (cmd_r.vd_addr),
        .beat_idx          (beat_idx_r),
        .remaining         (remaining_s),
        .addr              (addr_s),
        .elements_to_write (ete_s)
    );

    // Control FSM with registered handshake and write-port outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r              <= WB_IDLE;
            cmd_r                <= '0;
            done_cnt_r           <= '0;
            beat_idx_r           <= 4'd0;
            err_pend_r           <= 1'b0;
            cmd_ready            <= 1'b1;
            res_ready            <= 1'b0;
            wb_write             <= 1'b0;
            wb_vd_addr           <= 5'd0;
            wb_elements_to_write <= 2'd0;
            wb_vsew              <= 2'd0;
            wb_widening          <= 1'b0;
            wb_vd_data           <= '0;
            done                 <= 1'b0;
            err                  <= 1'b0;
        end else begin
            done     <= 1'b0;
            err      <= 1'b0;
            wb_write <= 1'b0;
            case (state_r)
                WB_IDLE: begin
                    if (cmd_valid) begin
                        cmd_r.vd_addr  <= cmd_vd_addr;
                        cmd_r.vl       <= cmd_vl;
                        cmd_r.vsew     <= cmd_vsew;
                        cmd_r.widening <= cmd_widening;
                        cmd_ready      <= 1'b0;
                        done_cnt_r     <= '0;
                        beat_idx_r     <= 4'd0;
                        if ((cmd_widening && (cmd_vsew != 2'd0)) || (cmd_vsew == 2'd3)) begin
                            err_pend_r <= 1'b1;
                            state_r    <= WB_FINISH;
                        end else if (cmd_vl == 5'd0) begin
                            err_pend_r <= 1'b0;
                            state_r    <= WB_FINISH;
                        end else begin
                            err_pend_r <= 1'b0;
                            res_ready  <= 1'b1;
                            state_r    <= WB_ACTIVE;
                        end
                    end
                end
                WB_ACTIVE: begin
                    if (accept_s) begin
                        wb_write             <= 1'b1;
                        wb_vd_addr           <= addr_s;
                        wb_elements_to_write <= ete_s;
                        wb_vsew              <= cmd_r.vsew;
                        wb_widening          <= cmd_r.widening;
                        wb_vd_data           <= res_data;
                        done_cnt_r           <= done_cnt_r + take_s;
                        beat_idx_r           <= beat_idx_r + 4'd1;
                        // Drop ready with the last write so no extra beat slips in.
                        if (last_s) begin
                            res_ready <= 1'b0;
                            state_r   <= WB_FINISH;
                        end
                    end
                end
                WB_FINISH: begin
                    done      <= 1'b1;
                    err       <= err_pend_r;
                    cmd_ready <= 1'b1;
                    state_r   <= WB_IDLE;
                end
                default: begin
                    cmd_ready <= 1'b1;
                    res_ready <= 1'b0;
                    state_r   <= WB_IDLE;
                end
            endcase
        end
    end

`ifdef AVA_WB_STATS_EN
    // Saturating beat and stall counters, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_beats  <= 16'd0;
            stat_stalls <= 16'd0;
        end else begin
            if (accept_s && (stat_beats != 16'hFFFF)) begin
                stat_beats <= stat_beats + 16'd1;
            end
            if ((state_r == WB_ACTIVE) && !res_valid && (stat_stalls != 16'hFFFF)) begin
                stat_stalls <= stat_stalls + 16'd1;
            end
        end
    end
`else
    assign stat_beats  = 16'd0;
    assign stat_stalls = 16'd0;
`endif

endmodule

// File: tb/tb_vector_writeback_sequencer.sv
// Directed table-driven bench for vector_writeback_sequencer.
module tb_vector_writeback_sequencer;

    logic         clk = 1'b0;
    logic         reset;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [4:0]   cmd_vd_addr;
    logic [4:0]   cmd_vl;
    logic [1:0]   cmd_vsew;
    logic         cmd_widening;
    logic         res_valid;
    logic         res_ready;
    logic [127:0] res_data;
    logic         wb_write;
    logic [4:0]   wb_vd_addr;
    logic [1:0]   wb_elements_to_write;
    logic [1:0]   wb_vsew;
    logic         wb_widening;
    logic [127:0] wb_vd_data;
    logic         done;
    logic         err;
    logic [15:0]  stat_beats;
    logic [15:0]  stat_stalls;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [4:0]      vd;
        logic [4:0]      vl;
        logic [1:0]      vsew;
        logic            wid;
        int              nwr;
        logic [3:0][4:0] addr;
        logic [3:0][1:0] ete;
        logic            err;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    vector_writeback_sequencer dut (
        .clk                  (clk),
        .reset                (reset),
        .cmd_valid            (cmd_valid),
        .cmd_ready            (cmd_ready),
        .cmd_vd_addr          (cmd_vd_addr),
        .cmd_vl               (cmd_vl),
        .cmd_vsew             (cmd_vsew),
        .cmd_widening         (cmd_widening),
        .res_valid            (res_valid),
        .res_ready            (res_ready),
        .res_data             (res_data),
        .wb_write             (wb_write),
        .wb_vd_addr           (wb_vd_addr),
        .wb_elements_to_write (wb_elements_to_write),
        .wb_vsew              (wb_vsew),
        .wb_widening          (wb_widening),
        .wb_vd_data           (wb_vd_data),
        .done                 (done),
        .err                  (err),
        .stat_beats           (stat_beats),
        .stat_stalls          (stat_stalls)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] pat(input int n);
        logic [31:0] k;
        k = 32'(n);
        return {32'h1100_0000 + k, 32'h2200_0000 + k, 32'h3300_0000 + k, 32'h4400_0000 + k};
    endfunction

    task automatic add_vec(input logic [4:0] vd, input logic [4:0] vl, input logic [1:0] vsew,
                           input logic wid, input int nwr, input logic [4:0] a0, input logic [4:0] a1,
                           input logic [4:0] a2, input logic [4:0] a3, input logic [1:0] e0,
                           input logic [1:0] e1, input logic [1:0] e2, input logic [1:0] e3,
                           input logic e);
        vec_t v;
        v.vd = vd; v.vl = vl; v.vsew = vsew; v.wid = wid; v.nwr = nwr;
        v.addr = {a3, a2, a1, a0};
        v.ete  = {e3, e2, e1, e0};
        v.err  = e;
        vecs.push_back(v);
    endtask

    // Issue one command with res_valid held high and check every write and the done pulse.
    task automatic run_vec(input vec_t v, input int seed);
        logic hs;
        int   nw;
        int   sent;
        bit   got;
        nw = 0; sent = 0; got = 1'b0;
        cmd_vd_addr = v.vd; cmd_vl = v.vl; cmd_vsew = v.vsew; cmd_widening = v.wid;
        cmd_valid = 1'b1;
        res_valid = 1'b1;
        res_data  = pat(seed);
        step();
        cmd_valid = 1'b0;
        chk("cmd_ready_drop", cmd_ready, 1'b0);
        for (int cyc = 0; cyc < 16 && !got; cyc++) begin
            hs = res_valid && res_ready;
            step();
            if (hs) begin
                sent++;
                res_data = pat(seed + sent);
            end
            chk("wb_write_latency", wb_write, hs);
            if (wb_write) begin
                if (nw < v.nwr) begin
                    chk("wb_vd_addr", wb_vd_addr, v.addr[nw]);
                    chk("wb_ete", wb_elements_to_write, v.ete[nw]);
                    chk("wb_vd_data", wb_vd_data, pat(seed + nw));
                    chk("wb_vsew", wb_vsew, v.vsew);
                    chk("wb_widening", wb_widening, v.wid);
                    chk("res_ready_after_write", res_ready, (nw == v.nwr - 1) ? 1'b0 : 1'b1);
                end
                nw++;
            end
            if (done) begin
                got = 1'b1;
                chk("done_cycle", cyc, v.nwr);
                chk("err", err, v.err);
                chk("cmd_ready_at_done", cmd_ready, 1'b1);
            end else begin
                chk("err_without_done", err, 1'b0);
            end
        end
        chk("done_seen", got, 1'b1);
        chk("write_count", nw, v.nwr);
        res_valid = 1'b0;
        step();
        chk("done_single_pulse", done, 1'b0);
        chk("wb_write_idle", wb_write, 1'b0);
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_vd_addr = 5'd0; cmd_vl = 5'd0; cmd_vsew = 2'd0;
        cmd_widening = 1'b0; res_valid = 1'b0; res_data = 128'd0;

        //            vd     vl     sew   wid n  addr0..3                   ete0..3                err
        add_vec(5'd4,  5'd10, 2'd0, 1'b0, 3, 5'd4,  5'd5,  5'd6, 5'd0,  2'd0, 2'd0, 2'd2, 2'd0, 1'b0);
        add_vec(5'd8,  5'd8,  2'd1, 1'b0, 2, 5'd8,  5'd10, 5'd0, 5'd0,  2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
        add_vec(5'd2,  5'd3,  2'd0, 1'b1, 1, 5'd2,  5'd0,  5'd0, 5'd0,  2'd3, 2'd0, 2'd0, 2'd0, 1'b0);
        add_vec(5'd30, 5'd8,  2'd2, 1'b0, 2, 5'd30, 5'd2,  5'd0, 5'd0,  2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
        add_vec(5'd1,  5'd4,  2'd2, 1'b1, 0, 5'd0,  5'd0,  5'd0, 5'd0,  2'd0, 2'd0, 2'd0, 2'd0, 1'b1);
        add_vec(5'd0,  5'd4,  2'd3, 1'b0, 0, 5'd0,  5'd0,  5'd0, 5'd0,  2'd0, 2'd0, 2'd0, 2'd0, 1'b1);
        add_vec(5'd6,  5'd0,  2'd0, 1'b0, 0, 5'd0,  5'd0,  5'd0, 5'd0,  2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
        add_vec(5'd6,  5'd4,  2'd1, 1'b1, 0, 5'd0,  5'd0,  5'd0, 5'd0,  2'd0, 2'd0, 2'd0, 2'd0, 1'b1);
        add_vec(5'd31, 5'd5,  2'd0, 1'b0, 2, 5'd31, 5'd0,  5'd0, 5'd0,  2'd0, 2'd1, 2'd0, 2'd0, 1'b0);
        add_vec(5'd0,  5'd2,  2'd1, 1'b0, 1, 5'd0,  5'd0,  5'd0, 5'd0,  2'd2, 2'd0, 2'd0, 2'd0, 1'b0);
        add_vec(5'd4,  5'd16, 2'd0, 1'b1, 4, 5'd4,  5'd6,  5'd8, 5'd10, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);

        // Reset state.
        step(); step();
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_res_ready", res_ready, 1'b0);
        chk("rst_wb_write", wb_write, 1'b0);
        chk("rst_wb_vd_addr", wb_vd_addr, 5'd0);
        chk("rst_wb_vd_data", wb_vd_data, 128'd0);
        chk("rst_done_err", {done, err}, 2'b00);
        chk("rst_stats", {stat_beats, stat_stalls}, 32'd0);
        reset = 1'b0;
        step();

        // 32b single beat with two idle cycles before the result arrives.
        cmd_vd_addr = 5'd16; cmd_vl = 5'd4; cmd_vsew = 2'd2; cmd_widening = 1'b0;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        chk("gap_res_ready", res_ready, 1'b1);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("gap_no_write", wb_write, 1'b0);
            chk("gap_res_ready_held", res_ready, 1'b1);
        end
        res_valid = 1'b1;
        res_data  = pat(500);
        step();
        res_valid = 1'b0;
        chk("gap_write", wb_write, 1'b1);
        chk("gap_addr", wb_vd_addr, 5'd16);
        chk("gap_ete", wb_elements_to_write, 2'd0);
        chk("gap_data", wb_vd_data, pat(500));
        chk("gap_res_ready_drop", res_ready, 1'b0);
        step();
        chk("gap_done", {done, err, wb_write}, 3'b100);
`ifdef AVA_WB_STATS_EN
        chk("gap_stat_stalls", stat_stalls, 16'd2);
        chk("gap_stat_beats", stat_beats, 16'd1);
`else
        chk("gap_stat_stalls", stat_stalls, 16'd0);
        chk("gap_stat_beats", stat_beats, 16'd0);
`endif
        step();

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], 16 * i);
        end

        // Reset after the first of three beats, then a clean command.
        cmd_vd_addr = 5'd4; cmd_vl = 5'd12; cmd_vsew = 2'd0; cmd_widening = 1'b0;
        cmd_valid = 1'b1;
        res_valid = 1'b1;
        res_data  = pat(900);
        step();
        cmd_valid = 1'b0;
        step();
        chk("midrst_first_write", wb_write, 1'b1);
        reset = 1'b1;
        #1;
        chk("midrst_async_write", wb_write, 1'b0);
        step();
        res_valid = 1'b0;
        chk("midrst_cmd_ready", cmd_ready, 1'b1);
        chk("midrst_outputs", {res_ready, wb_write, done, err, wb_vd_addr}, 9'd0);
        reset = 1'b0;
        step();
        run_vec(vecs[2], 700);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
